adder_ins_packer: RTL and testbench



---
 rtl/adder_pkg.sv | 25 ++
 rtl/adder_ref_sum.sv | 21 ++
 rtl/adder_ins_packer.sv | 116 +++++++++++
 tb/tb_adder_ins_packer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared widths, field positions and enums for the adder operand bundle
package adder_pkg;

  localparam int INS_W   = 33;
  localparam int X_LSB   = 0;
  localparam int Y_LSB   = 8;
  localparam int Z_LSB   = 16;
  localparam int W_LSB   = 24;
  localparam int CIN_BIT = 32;
  localparam int SM_W    = 10;

  typedef enum logic [2:0] {
    BEAT_X   = 3'd0,
    BEAT_Y   = 3'd1,
    BEAT_Z   = 3'd2,
    BEAT_W   = 3'd3,
    BEAT_CIN = 3'd4
  } beat_t;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/adder_ref_sum.sv
// rtl/adder_ref_sum.sv - combinational reference sum x + y[3:2] + z + w + cin of a packed bundle
module adder_ref_sum
  import adder_pkg::*;
(
  input  logic [INS_W-1:0] ins,
  output logic [SM_W-1:0]  sm
);

  // Only y[3:2] contributes to the adder's sum; the remaining y bits are deliberately ignored.
  logic unused_y;
  assign unused_y = ^{ins[Y_LSB +: 2], ins[Y_LSB+4 +: 4]};

  always_comb begin
    sm = SM_W'(ins[X_LSB +: 8])
       + SM_W'(ins[Y_LSB+2 +: 2])
       + SM_W'(ins[Z_LSB +: 8])
       + SM_W'(ins[W_LSB +: 8])
       + SM_W'(ins[CIN_BIT]);
  end

endmodule

// File: rtl/adder_ins_packer.sv
// rtl/adder_ins_packer.sv - packs five stream beats into the 33-bit adder ins bundle; ADDER_PACK_REF_SUM_EN adds exp_sm
module adder_ins_packer
  import adder_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int CIN_SEL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INS_W-1:0] ins,
  output logic             err_resync,
  output logic [CNT_W-1:0] pkt_cnt
`ifdef ADDER_PACK_REF_SUM_EN
  ,
  output logic [SM_W-1:0]  exp_sm
`endif
);

  state_t           state_q, state_d;
  beat_t            beat_q, beat_d;
  logic [31:0]      asm_q, asm_d;
  logic [INS_W-1:0] ins_q, next_ins;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q;
  logic             load_ins, in_hs, out_hs;

  // x/y/z/w live in asm_q so a drain-cycle x write cannot disturb the bundle being sampled.
  assign next_ins = {in_data[CIN_SEL], asm_q};

  assign in_ready   = (state_q == COLLECT) || out_ready;
  assign in_hs      = in_valid && in_ready;
  assign out_hs     = (state_q == HOLD) && out_ready;
  assign out_valid  = (state_q == HOLD);
  assign ins        = ins_q;
  assign err_resync = err_q;
  assign pkt_cnt    = cnt_q;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    asm_d    = asm_q;
    err_d    = 1'b0;
    load_ins = 1'b0;
    if (out_hs) state_d = COLLECT;
    if (in_hs) begin
      if (in_first) begin
        asm_d[X_LSB +: 8] = in_data;
        beat_d            = BEAT_Y;
        err_d             = (beat_q != BEAT_X);
      end else begin
        case (beat_q)
          BEAT_X: err_d = 1'b1;
          BEAT_Y: begin
            asm_d[Y_LSB +: 8] = in_data;
            beat_d            = BEAT_Z;
          end
          BEAT_Z: begin
            asm_d[Z_LSB +: 8] = in_data;
            beat_d            = BEAT_W;
          end
          BEAT_W: begin
            asm_d[W_LSB +: 8] = in_data;
            beat_d            = BEAT_CIN;
          end
          BEAT_CIN: begin
            load_ins = 1'b1;
            beat_d   = BEAT_X;
            state_d  = HOLD;
          end
          default: beat_d = BEAT_X;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      beat_q  <= BEAT_X;
      asm_q   <= '0;
      ins_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      asm_q   <= asm_d;
      err_q   <= err_d;
      if (load_ins) ins_q <= next_ins;
      if (out_hs) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef ADDER_PACK_REF_SUM_EN
  logic [SM_W-1:0] sm_next, sm_q;

  adder_ref_sum u_ref_sum (
    .ins (next_ins),
    .sm  (sm_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sm_q <= '0;
    else if (load_ins) sm_q <= sm_next;
  end

  assign exp_sm = sm_q;
`endif

endmodule

// File: tb/tb_adder_ins_packer.sv
// tb/tb_adder_ins_packer.sv - directed and randomized checks of adder_ins_packer against a packet-level model
module tb_adder_ins_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        in_ready, out_valid, err_resync;
  logic [32:0] ins;
  logic [7:0]  pkt_cnt;
  logic        in_ready7, out_valid7, err_resync7;
  logic [32:0] ins7;
  logic [7:0]  pkt_cnt7;
`ifdef ADDER_PACK_REF_SUM_EN
  logic [9:0]  exp_sm, exp_sm7;
`endif

  always #5 clk = ~clk;

  adder_ins_packer #(.CNT_W(8), .CIN_SEL(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_first(in_first), .out_valid(out_valid),
    .out_ready(out_ready), .ins(ins), .err_resync(err_resync), .pkt_cnt(pkt_cnt)
`ifdef ADDER_PACK_REF_SUM_EN
    , .exp_sm(exp_sm)
`endif
  );

  adder_ins_packer #(.CNT_W(8), .CIN_SEL(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready7),
    .in_data(in_data), .in_first(in_first), .out_valid(out_valid7),
    .out_ready(out_ready), .ins(ins7), .err_resync(err_resync7), .pkt_cnt(pkt_cnt7)
`ifdef ADDER_PACK_REF_SUM_EN
    , .exp_sm(exp_sm7)
`endif
  );

  // Packet-level model: bytes of the packet in progress plus the delivered-bundle view.
  logic [7:0]  part[$];
  logic [32:0] m_ins0, m_ins7;
  logic        m_valid;
  logic        m_err;
  logic [7:0]  m_cnt;
  int          checks = 0;
  int          passes = 0;

  function automatic logic [9:0] ref_sum(input logic [32:0] b);
    int s;
    s = b[7:0] + b[11:10] + b[23:16] + b[31:24] + b[32];
    return s[9:0];
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    part.delete();
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 8'd0;
    m_ins0  = 33'd0;
    m_ins7  = 33'd0;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic f,
                       input logic ordy, output logic acc);
    logic err_now;
    @(negedge clk);
    in_valid = v; in_data = d; in_first = f; out_ready = ordy;
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("out_valid7", out_valid7, m_valid);
    chk("in_ready", in_ready, !m_valid || ordy);
    chk("in_ready7", in_ready7, !m_valid || ordy);
    chk("err_resync", err_resync, m_err);
    chk("err_resync7", err_resync7, m_err);
    chk("pkt_cnt", pkt_cnt, m_cnt);
    chk("pkt_cnt7", pkt_cnt7, m_cnt);
    if (m_valid) begin
      chk("ins", ins, m_ins0);
      chk("ins7", ins7, m_ins7);
`ifdef ADDER_PACK_REF_SUM_EN
      chk("exp_sm", exp_sm, ref_sum(m_ins0));
      chk("exp_sm7", exp_sm7, ref_sum(m_ins7));
`endif
    end
    acc = v && (!m_valid || ordy);
    err_now = 1'b0;
    if (m_valid && ordy) begin
      m_valid = 1'b0;
      m_cnt   = m_cnt + 8'd1;
    end
    if (acc) begin
      if (f) begin
        err_now = (part.size() != 0);
        part.delete();
        part.push_back(d);
      end else if (part.size() == 0) begin
        err_now = 1'b1;
      end else begin
        part.push_back(d);
        if (part.size() == 5) begin
          m_ins0  = {part[4][0], part[3], part[2], part[1], part[0]};
          m_ins7  = {part[4][7], part[3], part[2], part[1], part[0]};
          m_valid = 1'b1;
          part.delete();
        end
      end
    end
    m_err = err_now;
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, ordy, acc);
  endtask

  // rnd_ordy: out_ready random on early attempts, forced high later so the wait stays bounded.
  task automatic send(input logic [7:0] d, input logic f, input logic ordy, input logic rnd_ordy);
    logic acc;
    logic o;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      o = rnd_ordy ? ((t > 3) ? 1'b1 : 1'($urandom_range(0, 1))) : ordy;
      cycle(1'b1, d, f, o, acc);
    end
    chk("beat_accepted", acc, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ins", ins, 33'd0);
    chk("rst_err", err_resync, 1'b0);
    chk("rst_pkt_cnt", pkt_cnt, 8'd0);
    chk("rst_ins7", ins7, 33'd0);
`ifdef ADDER_PACK_REF_SUM_EN
    chk("rst_exp_sm", exp_sm, 10'd0);
`endif
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4, input logic ordy);
    send(b0, 1'b1, ordy, 1'b0);
    send(b1, 1'b0, ordy, 1'b0);
    send(b2, 1'b0, ordy, 1'b0);
    send(b3, 1'b0, ordy, 1'b0);
    send(b4, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] cnt_start;
    logic [7:0] nx;
    model_reset();
    do_reset();
    idle(2, 1'b1);

    // Basic packet
    send_pkt(8'h12, 8'h0C, 8'h34, 8'h56, 8'h01, 1'b1);
    idle(1, 1'b0);
    chk("basic_ins", ins, 33'h1_5634_0C12);
    chk("basic_ins7", ins7, 33'h0_5634_0C12);
    chk("basic_cnt0", pkt_cnt, 8'd0);
`ifdef ADDER_PACK_REF_SUM_EN
    chk("basic_exp_sm", exp_sm, 10'h0A0);
`endif
    idle(2, 1'b1);
    chk("basic_cnt1", pkt_cnt, 8'd1);

    // Backpressure, then next x accepted in the drain cycle
    send_pkt(8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic acc;
      cycle(1'b1, 8'h5A, 1'b1, 1'b0, acc);
      chk("bp_not_taken", acc, 1'b0);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    chk("bp_ins_held", ins, 33'h1_D4C3_B2A1);
    send(8'h5A, 1'b1, 1'b1, 1'b0);
    send(8'h6B, 1'b0, 1'b1, 1'b0);
    send(8'h7C, 1'b0, 1'b1, 1'b0);
    send(8'h8D, 1'b0, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0);
    chk("bp_next_ins", ins, 33'h0_8D7C_6B5A);
    idle(2, 1'b1);

    // Resync on a mid-packet first marker
    send(8'hAA, 1'b1, 1'b1, 1'b0);
    send(8'hBB, 1'b0, 1'b1, 1'b0);
    send(8'h11, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);
    chk("resync_pulse", err_resync, 1'b1);
    send(8'h22, 1'b0, 1'b1, 1'b0);
    send(8'h33, 1'b0, 1'b1, 1'b0);
    send(8'h44, 1'b0, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0);
    chk("resync_ins", ins, 33'h0_4433_2211);
    idle(2, 1'b1);

    // Stray beat at index 0, then back-to-back strays
    send(8'h77, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b1);
    chk("stray_pulse", err_resync, 1'b1);
    send(8'h78, 1'b0, 1'b1, 1'b0);
    send(8'h79, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("stray_no_valid", out_valid, 1'b0);

    // 256 randomized packets: counter must wrap back to its start value
    cnt_start = m_cnt;
    for (int p = 0; p < 256; p++) begin
      send(8'($urandom), 1'b1, 1'b1, 1'b1);
      if ($urandom_range(0, 7) == 0) begin
        send(8'($urandom), 1'b0, 1'b1, 1'b1);
        send(8'($urandom), 1'b1, 1'b1, 1'b1);
      end
      for (int b = 1; b < 5; b++) begin
        if ($urandom_range(0, 3) == 0) idle(1, 1'($urandom_range(0, 1)));
        send(8'($urandom), 1'b0, 1'b1, 1'b1);
      end
    end
    for (int t = 0; t < 20 && m_valid; t++) idle(1, 1'($urandom_range(0, 1)));
    idle(1, 1'b1);
    chk("wrap_drained", out_valid, 1'b0);
    chk("wrap_cnt", pkt_cnt, cnt_start);

    // cin select
    send_pkt(8'h01, 8'h02, 8'h03, 8'h04, 8'h80, 1'b1);
    idle(1, 1'b0);
    chk("cin7_set", ins7[32], 1'b1);
    chk("cin0_clear", ins[32], 1'b0);
    idle(1, 1'b1);
    send_pkt(8'h01, 8'h02, 8'h03, 8'h04, 8'h7F, 1'b1);
    idle(1, 1'b0);
    chk("cin7_clear", ins7[32], 1'b0);
    chk("cin0_set", ins[32], 1'b1);
    idle(2, 1'b1);

    // Reset mid-packet, then a clean packet
    send(8'hE1, 1'b1, 1'b1, 1'b0);
    send(8'hE2, 1'b0, 1'b1, 1'b0);
    send(8'hE3, 1'b0, 1'b1, 1'b0);
    do_reset();
    idle(1, 1'b1);
    nx = 8'h3C;
    send_pkt(nx, 8'h4D, 8'h5E, 8'h6F, 8'h01, 1'b1);
    idle(1, 1'b0);
    chk("post_rst_ins", ins, 33'h1_6F5E_4D3C);
    idle(2, 1'b1);
    chk("post_rst_cnt", pkt_cnt, 8'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
